// File: rtl/fpu_issue_queue.sv
// Command FIFO in front of a fixed-latency FPU: pops one command at a time, waits LATENCY
// cycles for the result and holds it for downstream until accepted.
module fpu_issue_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_A,
    input  logic [31:0]            in_B,
    input  logic [1:0]             in_Sel,
    input  logic [1:0]             in_round,
    output logic [31:0]            fpu_A,
    output logic [31:0]            fpu_B,
    output logic [1:0]             fpu_Sel,
    output logic [1:0]             fpu_round,
    output logic                   fpu_start,
    input  logic [31:0]            fpu_Y,
    input  logic                   fpu_Overflow,
    input  logic                   fpu_Error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_Y,
    output logic                   out_Overflow,
    output logic                   out_Error,
    output logic [1:0]             out_Sel,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned LatW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic [1:0]  rnd;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [LatW-1:0] lat_q, lat_d;
    cmd_t            fpu_cmd_q, fpu_cmd_d;
    logic            fpu_start_q, fpu_start_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_y_q, out_y_d;
    logic            out_ovf_q, out_ovf_d;
    logic            out_err_q, out_err_d;
    logic [1:0]      out_sel_q, out_sel_d;
    logic            push, pop;

    // Ready comes from the registered count only, so a full queue never accepts even when popping.
    assign in_ready = (count_q < CntW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        fpu_cmd_d   = fpu_cmd_q;
        fpu_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        out_sel_d   = out_sel_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    fpu_cmd_d   = mem_q[rd_ptr_q];
                    fpu_start_d = 1'b1;
                    lat_d       = LatW'(LATENCY);
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (lat_q == LatW'(1)) begin
                    out_y_d     = fpu_Y;
                    out_ovf_d   = fpu_Overflow;
                    out_err_d   = fpu_Error;
                    out_sel_d   = fpu_cmd_q.sel;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Queue storage needs no reset: entries are only read behind the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{a: in_A, b: in_B, sel: in_Sel, rnd: in_round};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lat_q       <= '0;
            fpu_cmd_q   <= '0;
            fpu_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lat_q       <= lat_d;
            fpu_cmd_q   <= fpu_cmd_d;
            fpu_start_q <= fpu_start_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign fpu_A        = fpu_cmd_q.a;
    assign fpu_B        = fpu_cmd_q.b;
    assign fpu_Sel      = fpu_cmd_q.sel;
    assign fpu_round    = fpu_cmd_q.rnd;
    assign fpu_start    = fpu_start_q;
    assign out_valid    = out_valid_q;
    assign out_Y        = out_y_q;
    assign out_Overflow = out_ovf_q;
    assign out_Error    = out_err_q;
    assign out_Sel      = out_sel_q;
    assign count        = count_q;
    assign busy         = (state_q != StIdle);

endmodule
